fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; power of two, 2..16.
REQ-003 The block SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports req_valid out 1, req_ready in 1, req_addr out 32: instruction-memory request.
REQ-006 The block SHALL have ports rsp_valid in 1, rsp_data in 32: in-order memory response, always accepted.
REQ-007 The block SHALL have ports Redirect in 1, RedirectPC in 32: taken branch/jump from the datapath.
REQ-008 The block SHALL have ports InstrValid out 1, InstrReady in 1, Instruction out 32, InstrPC out 32: delivery to the datapath.
REQ-009 The block SHALL have port AlignFault out 1, sticky misaligned-redirect flag (see REQ-026).

Function
REQ-010 The FSM SHALL have states IDLE, RUN and HALT; reset enters IDLE; IDLE->RUN unconditionally on the first edge after reset release.
REQ-011 req_valid SHALL be high only in RUN, with Redirect low, and outstanding + queue occupancy < DEPTH (credit rule).
REQ-012 req_addr SHALL equal the fetch PC; on req_valid && req_ready the fetch PC SHALL advance by 4 (mod 2^32 wrap) and outstanding SHALL increment.
REQ-013 Each rsp_valid SHALL decrement outstanding; if discard > 0 the response SHALL be dropped and discard decremented, else {PC, rsp_data} SHALL be pushed to the queue.
REQ-014 Response PCs SHALL come from an internal issue-PC counter that advances per accepted response, so InstrPC matches the address requested.
REQ-015 InstrValid SHALL equal queue-not-empty; Instruction/InstrPC SHALL show the head entry; pop on InstrValid && InstrReady.
REQ-016 When the queue is empty, Instruction SHALL read 32'h0000_0013 (NOP) and InstrPC SHALL hold its last value.
REQ-017 Push and pop in the same cycle SHALL both take effect; occupancy is unchanged; credits guarantee no overflow.
REQ-018 Redirect SHALL take priority. In that cycle: any pop completes, then the queue is flushed, the fetch PC and issue PC are loaded with RedirectPC, and discard is set to outstanding minus rsp_valid.
REQ-019 A response arriving in the Redirect cycle SHALL be dropped.
REQ-020 Redirect in IDLE SHALL still load the PC; Redirect during a pending discard SHALL recompute discard per REQ-018.
REQ-021 Minimum latency: req accepted at edge N, rsp_valid at N+k, InstrValid high in the cycle after edge N+k.

Reset
REQ-022 On Reset low, asynchronously: state IDLE, req_valid 0, req_addr RESET_PC, InstrValid 0, Instruction 32'h0000_0013, InstrPC 0, AlignFault 0, queue empty.
REQ-023 On Reset low, asynchronously: outstanding 0 and discard 0.
REQ-024 Reset asserted mid-transaction SHALL abandon in-flight requests; responses received after release with outstanding = 0 SHALL be ignored.

Configuration
REQ-025 Macro FETCH_ALIGN_CHECK_EN SHALL select misaligned-redirect handling.
REQ-026 With FETCH_ALIGN_CHECK_EN defined: Redirect with RedirectPC[1:0] != 0 SHALL set AlignFault, flush the queue, and enter HALT (no requests); only Reset exits HALT.
REQ-027 Without FETCH_ALIGN_CHECK_EN: RedirectPC[1:0] SHALL be forced to 0, AlignFault SHALL be tied 0, and HALT is unreachable.

Structure
REQ-028 Shared package riscv_pkg SHALL hold XLEN = 32, NOP_INSTR = 32'h0000_0013, and the fetch_state_t enum {IDLE, RUN, HALT}.
REQ-029 The queue SHALL be a sub-module fetch_queue (synchronous FIFO, 64-bit entries, push/pop/flush, count output).

Verification
REQ-030 Reset release with RESET_PC = 0, req_ready = 1, rsp after 1 cycle, InstrReady = 1 -> req_addr 0,4,8,...; Instruction/InstrPC pairs delivered in order; first InstrValid 3 cycles after release.
REQ-031 InstrReady = 0, DEPTH = 4 -> exactly 4 requests issued, req_valid stays low; after InstrReady rises, one new request per pop.
REQ-032 Redirect to 32'h0000_0100 with 2 outstanding -> next 2 responses dropped, queue empty the next cycle, next delivered InstrPC = 32'h100.
REQ-033 Simultaneous push and pop with a full queue for 10 cycles -> count constant at 4, no lost or duplicated PC.
REQ-034 Redirect to 32'h0000_0102 -> with the macro: AlignFault = 1, req_valid = 0 until Reset; without it: fetch from 32'h100.
REQ-035 Reset asserted while 3 responses are outstanding -> all outputs at reset values immediately; late responses are not delivered.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : encoding of addi x0,x0,0, shown when nothing is queued
//   fetch_state_t : fetch sequencer states
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of {pc, instruction} entries.
// Ports:
//   clock, Reset        : rising-edge clock, async active-low reset
//   push, push_data     : write an entry at the tail
//   pop                 : drop the head entry
//   flush               : empty the queue (wins over push/pop)
//   head                : head entry, only meaningful while !empty
//   empty, count        : occupancy status
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  // Credits upstream should make overflow impossible; guard anyway.
  assign push_ok = push && ((count != DEPTH_C) || pop_ok);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests, collects in-order
// responses into a prefetch queue and hands {Instruction, InstrPC} to the
// datapath. Redirects flush the queue and discard responses still in flight.
//
// Build option: FETCH_ALIGN_CHECK_EN -- when defined, a redirect to a
// non-word-aligned target raises AlignFault and parks the unit in HALT until
// reset; otherwise the target's low two bits are cleared.
//
// Ports:
//   clock, Reset            : rising-edge clock, async active-low reset
//   req_valid/ready/addr    : instruction-memory request
//   rsp_valid/rsp_data      : in-order memory response, always accepted
//   Redirect/RedirectPC     : taken branch/jump from the datapath
//   InstrValid/Ready        : delivery handshake to the datapath
//   Instruction/InstrPC     : head instruction and its address
//   AlignFault              : sticky misaligned-redirect flag
//
// state | meaning
// IDLE  | one cycle after reset release, no requests
// RUN   | fetching, credit-limited
// HALT  | misaligned redirect seen, no requests until reset
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic            clock,
  input  logic            Reset,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectPC,
  output logic            InstrValid,
  input  logic            InstrReady,
  output logic [XLEN-1:0] Instruction,
  output logic [XLEN-1:0] InstrPC,
  output logic            AlignFault
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] issue_pc;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   q_count;
  logic [CW:0]     credits_used;
  logic            align_fault;
  logic            misaligned;
  logic            redirect_act;
  logic            rsp_live;
  logic            req_fire;
  logic            q_push;
  logic            q_pop;
  logic            q_empty;
  logic [2*XLEN-1:0] q_head;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_pc = RedirectPC;
  assign misaligned  = (RedirectPC[1:0] != 2'b00);
`else
  assign redirect_pc = RedirectPC & ~32'h3;
  assign misaligned  = 1'b0;
`endif

  // HALT ignores redirects; only reset leaves it.
  assign redirect_act = Redirect && (state != HALT);
  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign rsp_live     = rsp_valid && (outstanding != '0);
  assign q_push       = rsp_live && !redirect_act && (discard == '0);
  assign q_pop        = InstrValid && InstrReady;

  assign credits_used = {1'b0, outstanding} + {1'b0, q_count};
  assign req_valid    = (state == RUN) && !Redirect && (credits_used < DEPTH_C);
  assign req_addr     = fetch_pc;
  assign req_fire     = req_valid && req_ready;

  assign InstrValid   = !q_empty;
  assign Instruction  = q_empty ? NOP_INSTR : q_head[XLEN-1:0];
  assign InstrPC      = q_empty ? last_pc   : q_head[2*XLEN-1:XLEN];
  assign AlignFault   = align_fault;

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (2*XLEN)
  ) u_queue (
    .clock     (clock),
    .Reset     (Reset),
    .push      (q_push),
    .push_data ({issue_pc, rsp_data}),
    .pop       (q_pop),
    .flush     (redirect_act),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      issue_pc    <= RESET_PC;
      last_pc     <= '0;
      outstanding <= '0;
      discard     <= '0;
      align_fault <= 1'b0;
    end else begin
      if (!q_empty) last_pc <= q_head[2*XLEN-1:XLEN];
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
      if (redirect_act) begin
        fetch_pc <= redirect_pc;
        issue_pc <= redirect_pc;
        // Everything still in flight after this edge predates the redirect.
        discard  <= outstanding - CW'(rsp_live);
        if (misaligned) begin
          state       <= HALT;
          align_fault <= 1'b1;
        end else if (state == IDLE) begin
          state <= RUN;
        end
      end else begin
        if (state == IDLE) state <= RUN;
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_live) begin
          if (discard != '0) discard  <= discard - 1'b1;
          else               issue_pc <= issue_pc + 32'd4;
        end
      end
    end
  end

endmodule
